bcd_sub_arbiter: RTL



---
 rtl/bcd_sub_arbiter_pkg.sv | 40 ++++
 rtl/bcd_sub_arbiter_digit_sub.sv | 27 ++
 rtl/bcd_sub_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bcd_sub_arbiter_pkg.sv
// Shared types and helpers for the round-robin BCD subtract arbiter.
// Digit width, controller states, BCD digit check and round-robin grant search.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned RR_MAX  = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  function automatic logic is_bcd_digit(input logic [DIGIT_W-1:0] nibble);
    return nibble <= 4'd9;
  endfunction

  // First valid requester strictly after 'pointer', wrapping modulo n (n <= RR_MAX).
  function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0] valid,
                                       input logic [2:0]        pointer,
                                       input int unsigned       n);
    rr_pick_t    r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= RR_MAX; k++) begin
      idx = (32'(pointer) + k) % n;
      if (k <= n && !r.found && valid[idx[2:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_sub_arbiter_digit_sub.sv
// Single BCD digit subtractor with borrow; combinational.
// Shared across all digit positions by the arbiter's controller.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] d,
  output logic               borrow_out
);

  logic [DIGIT_W:0] t;

  always_comb begin
    t = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, borrow_in};
    // Negative result: bit DIGIT_W is set; add ten modulo 16 to get the digit.
    if (t[DIGIT_W]) begin
      d          = t[DIGIT_W-1:0] + 4'd10;
      borrow_out = 1'b1;
    end else begin
      d          = t[DIGIT_W-1:0];
      borrow_out = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_sub_arbiter.sv
// Round-robin arbiter sharing one digit-serial BCD subtractor among N_REQ requesters.
// Operands are captured at grant, subtracted LSD first, result held until accepted.
module bcd_sub_arbiter
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DIGITS = 3,
  parameter int unsigned ID_W   = $clog2(N_REQ)
) (
  input  logic                        PCLK,
  input  logic                        PRESET,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DIGITS*4-1:0]   req_a,
  input  logic [N_REQ*DIGITS*4-1:0]   req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DIGITS*4-1:0]         rsp_diff,
  output logic                        rsp_borrow,
  output logic                        rsp_err,
  output logic                        busy
);

  localparam int unsigned W     = DIGITS * DIGIT_W;
  localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    id_r;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       b_sh;
  logic [W-1:0]       diff_acc;
  logic               borrow;
  logic               err_r;
  logic [CNT_W-1:0]   cnt;

  rr_pick_t           pick;
  logic [ID_W-1:0]    gnt;
  logic [W-1:0]       a_sel;
  logic [W-1:0]       b_sel;
  logic               sel_err;
  logic [DIGIT_W-1:0] d;
  logic               bout;
  logic               unused_pick;

  always_comb begin
    pick  = rr_pick(8'(req_valid), 3'(ptr), N_REQ);
    gnt   = ID_W'(pick.idx);
    a_sel = req_a[gnt*W +: W];
    b_sel = req_b[gnt*W +: W];
  end

  assign unused_pick = &{1'b0, pick};

  always_comb begin
    sel_err = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!is_bcd_digit(a_sel[i*DIGIT_W +: DIGIT_W]) ||
          !is_bcd_digit(b_sel[i*DIGIT_W +: DIGIT_W]))
        sel_err = 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && pick.found)
      req_ready[gnt] = 1'b1;
  end

  // Operand registers shift right each CALC cycle so the current digit is always at [3:0].
  bcd_digit_sub u_dsub (
    .a          (a_sh[DIGIT_W-1:0]),
    .b          (b_sh[DIGIT_W-1:0]),
    .borrow_in  (borrow),
    .d          (d),
    .borrow_out (bout)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state      <= IDLE;
      ptr        <= ID_W'(N_REQ - 1);
      id_r       <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      diff_acc   <= '0;
      borrow     <= 1'b0;
      err_r      <= 1'b0;
      cnt        <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_diff   <= '0;
      rsp_borrow <= 1'b0;
      rsp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick.found) begin
            a_sh     <= a_sel;
            b_sh     <= b_sel;
            id_r     <= gnt;
            ptr      <= gnt;
            err_r    <= sel_err;
            borrow   <= 1'b0;
            cnt      <= '0;
            diff_acc <= '0;
            busy     <= 1'b1;
            state    <= CALC;
          end
        end
        CALC: begin
          a_sh     <= a_sh >> DIGIT_W;
          b_sh     <= b_sh >> DIGIT_W;
          diff_acc <= {d, diff_acc[W-1:DIGIT_W]};
          borrow   <= bout;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DIGITS - 1)) begin
            state      <= DONE;
            rsp_valid  <= 1'b1;
            rsp_id     <= id_r;
            rsp_diff   <= err_r ? '0 : {d, diff_acc[W-1:DIGIT_W]};
            rsp_borrow <= !err_r && bout;
            rsp_err    <= err_r;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
